reg_file: RTL

//  Architectural register file; receiving end of the writeback port (regwrite/rd/regwdata).

---
 rtl/reg_file_if.sv | 29 ++
 rtl/reg_file.sv | 84 ++++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Writeback, issue-scoreboard and dual read-port bundle for the architectural register file.
interface reg_file_if #(
    parameter int AW = 6,
    parameter int W  = 32
);
    logic          regwrite;
    logic [AW-1:0] rd;
    logic [W-1:0]  regwdata;
    logic          rd_req;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [W-1:0]  rdata1;
    logic [W-1:0]  rdata2;
    logic          busy1;
    logic          busy2;
    logic          rvalid;
    logic          sb_set;
    logic [AW-1:0] sb_addr;

    modport master (
        output regwrite, rd, regwdata, rd_req, rs1, rs2, sb_set, sb_addr,
        input  rdata1, rdata2, busy1, busy2, rvalid
    );

    modport slave (
        input  regwrite, rd, regwdata, rd_req, rs1, rs2, sb_set, sb_addr,
        output rdata1, rdata2, busy1, busy2, rvalid
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: two registered read ports with write-through bypass,
// plus a per-register pending scoreboard set at issue and cleared at writeback.
module reg_file #(
    parameter int NREG = 64,
    parameter int AW   = 6,
    parameter int W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    logic [NREG-1:0][W-1:0] regs_q, regs_d;
    logic [NREG-1:0]        pend_q, pend_d;
    logic                   rvalid_q, rvalid_d;
    logic                   wr_en;
    logic [AW-1:0]          rs_addr [2];

    // Register 0 is hardwired: a write to it is neither stored nor clears/bypasses anything.
    assign wr_en      = bus.regwrite && (bus.rd != '0);
    assign rs_addr[0] = bus.rs1;
    assign rs_addr[1] = bus.rs2;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en) begin
            regs_d[bus.rd] = bus.regwdata;
            pend_d[bus.rd] = 1'b0;
        end
        // Applied after the clear so a newer in-flight producer keeps the register pending.
        if (bus.sb_set && (bus.sb_addr != '0)) begin
            pend_d[bus.sb_addr] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
        rvalid_d  = bus.rd_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '0;
            pend_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        logic         hit;
        logic [W-1:0] rdata_q, rdata_d;
        logic         busy_q, busy_d;

        // Same-cycle writeback to the addressed register is forwarded and its clear is visible.
        assign hit = wr_en && (bus.rd == rs_addr[gi]);

        always_comb begin
            rdata_d = rdata_q;
            busy_d  = busy_q;
            if (bus.rd_req) begin
                rdata_d = hit ? bus.regwdata : regs_q[rs_addr[gi]];
                busy_d  = pend_q[rs_addr[gi]] & ~hit;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                rdata_q <= rdata_d;
                busy_q  <= busy_d;
            end
        end
    end

    assign bus.rdata1 = g_rport[0].rdata_q;
    assign bus.rdata2 = g_rport[1].rdata_q;
    assign bus.busy1  = g_rport[0].busy_q;
    assign bus.busy2  = g_rport[1].busy_q;
    assign bus.rvalid = rvalid_q;
endmodule
